// File: rtl/mem_pkg.sv
// Shared types and default geometry for the memory responder.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one combinational read port, no reset.
module mem_array import mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with fixed response latency and
// alignment/range checking in front of a word array.
module mem_responder import mem_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam bit DIRECT = (LATENCY == 1);
  localparam logic [CNT_W-1:0] WAIT_CYC = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               accept, enter_resp, mem_we;
  logic               cur_we, cur_err;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_wdata, mem_rdata;
  logic [AW-1:0]      cur_idx;

  assign accept = req_valid && req_ready;

  // With single-cycle latency the edge entering RESP is the accept edge,
  // so the live request is decoded instead of the latched copy.
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_idx   = cur_addr[OFF_W +: AW];
  assign cur_err   = (|cur_addr[OFF_W-1:0]) || (|(cur_addr >> (OFF_W + AW)));

  assign enter_resp = (state_q == IDLE && accept && DIRECT) ||
                      (state_q == WAIT && cnt_q == '0);
  assign mem_we     = enter_resp && cur_we && !cur_err && !reset;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (cur_idx),
    .wdata_i (cur_wdata),
    .raddr_i (cur_idx),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture is gated by accept, which is already masked by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = DIRECT ? RESP : WAIT;
        cnt_d   = WAIT_CYC;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_we || cur_err) ? '0 : mem_rdata;
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model.
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam logic [63:0] BEEF = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] OLD20 = 64'h0123456789ABCDEF;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;

  mem_responder #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0, errs = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // resp_ready policy: 0 = always high, 1 = random, 2 = held low
  int rr_mode = 0;
  always begin
    @(posedge clk); #1;
    resp_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: at most one transaction in flight; its response is visible from
  // accept+LAT until the cycle resp_ready is seen high.
  bit          m_busy = 0, m_we, m_err;
  int          m_ta;
  logic [63:0] m_rdata, m_wdata;
  logic [7:0]  m_idx;
  logic [63:0] mm [DEPTH];
  int          n_acc = 0, n_done = 0;

  int          d_acc_cyc, d_vld_first, d_vld_run, d_hs_cyc;
  logic [63:0] d_rdata;
  logic        d_err;
  bit          prev_vld = 0;
  int          acc_q[$];

  always @(negedge clk) begin
    bit er, ev;
    logic [63:0] a;
    if (cyc >= 1) begin
      er = !m_busy && !reset;
      ev = m_busy && (cyc >= m_ta + LAT);
      chk("req_ready", req_ready, er);
      chk("resp_valid", resp_valid, ev);
      if (ev) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", resp_err, m_err);
      end
      if (req_valid && req_ready) begin d_acc_cyc = cyc; acc_q.push_back(cyc); end
      if (resp_valid && !prev_vld) begin d_vld_first = cyc; d_vld_run = 0; end
      if (resp_valid) d_vld_run++;
      if (resp_valid && resp_ready) begin d_hs_cyc = cyc; d_rdata = resp_rdata; d_err = resp_err; end
      prev_vld = resp_valid;

      if (ev && cyc == m_ta + LAT && m_we && !m_err) mm[m_idx] = m_wdata;
      if (reset) m_busy = 0;
      else if (er && req_valid) begin
        a       = req_addr;
        m_busy  = 1;
        m_ta    = cyc;
        m_we    = req_we;
        m_wdata = req_wdata;
        m_err   = (a[2:0] != 3'd0) || (a >= 64'(DEPTH * 8));
        m_idx   = a[10:3];
        m_rdata = (req_we || m_err) ? 64'd0 : mm[a[10:3]];
        n_acc++;
      end else if (ev && resp_ready) begin
        m_busy = 0;
        n_done++;
      end
    end
  end

  // One transaction; junk is driven on the request side while it is in flight.
  task automatic xact(input logic we, input logic [63:0] a, input logic [63:0] d);
    int na, nd, k;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    na = n_acc; k = 0;
    while (n_acc == na && k < 50) begin @(posedge clk); #1; k++; end
    chk("accept wait", 64'(n_acc != na), 64'd1);
    nd = n_done; k = 0;
    while (n_done == nd && k < 200) begin
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b0;
    chk("response wait", 64'(n_done != nd), 64'd1);
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 70)      return {53'd0, 8'($urandom_range(0, 255)), 3'd0};
    else if (r < 82) return {53'd0, 11'($urandom_range(0, 2047))};
    else if (r < 90) return 64'h800 + 64'($urandom_range(0, 63));
    else             return {$urandom, $urandom};
  endfunction

  int rise_cyc;
  initial begin
    logic [63:0] al [4];
    int na, nd, k;
    al[0] = 64'h10; al[1] = 64'h20; al[2] = 64'h7F8; al[3] = 64'h13;

    repeat (3) @(posedge clk); #1;
    chk("ready during reset", req_ready, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rdata after reset", resp_rdata, 0);
    chk("err after reset", resp_err, 0);
    chk("valid after reset", resp_valid, 0);
    chk("ready after reset", req_ready, 1);

    rr_mode = 1;
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 64'(i * 8), {$urandom, $urandom});

    rr_mode = 0;
    xact(1'b1, 64'h10, BEEF);
    chk("store latency", d_vld_first - d_acc_cyc, LAT);
    chk("store rdata", d_rdata, 0);
    chk("store err", d_err, 0);
    xact(1'b0, 64'h10, 64'd0);
    chk("load latency", d_vld_first - d_acc_cyc, LAT);
    chk("load rdata", d_rdata, BEEF);
    chk("load err", d_err, 0);

    rr_mode = 2;
    fork
      xact(1'b0, 64'h10, 64'd0);
      begin
        k = 0;
        @(posedge clk); #1;
        while (!resp_valid && k < 20) begin @(posedge clk); #1; k++; end
        repeat (5) @(posedge clk);
        rr_mode = 0;
        #1 rise_cyc = cyc;
      end
    join
    chk("stall valid cycles", d_vld_run, 6);
    chk("stall completion", d_hs_cyc, rise_cyc);
    chk("stall rdata", d_rdata, BEEF);

    xact(1'b1, 64'h13, 64'h5555_AAAA_5555_AAAA);
    chk("misaligned err", d_err, 1);
    chk("misaligned rdata", d_rdata, 0);
    xact(1'b0, 64'h10, 64'd0);
    chk("after misaligned", d_rdata, BEEF);

    xact(1'b0, 64'h800, 64'd0);
    chk("range err", d_err, 1);
    chk("range rdata", d_rdata, 0);
    xact(1'b1, 64'h7F8, 64'h7F87F87F87F87F87);
    xact(1'b0, 64'h7F8, 64'd0);
    chk("last word err", d_err, 0);
    chk("last word rdata", d_rdata, 64'h7F87F87F87F87F87);

    xact(1'b1, 64'h20, OLD20);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'hBAD0BAD0BAD0BAD0;
    na = n_acc; k = 0;
    while (n_acc == na && k < 50) begin @(posedge clk); #1; k++; end
    chk("abort accept", 64'(n_acc != na), 64'd1);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort valid", resp_valid, 0);
    @(posedge clk); #1;
    chk("abort ready", req_ready, 1);
    xact(1'b0, 64'h20, 64'd0);
    chk("abort old data", d_rdata, OLD20);

    acc_q.delete();
    nd = n_done;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = al[i]; na = n_acc; k = 0;
      while (n_acc == na && k < 20) begin @(posedge clk); #1; k++; end
    end
    req_valid = 1'b0;
    k = 0;
    while (n_done < nd + 4 && k < 50) begin @(posedge clk); #1; k++; end
    chk("b2b responses", n_done - nd, 4);
    chk("b2b accepts", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) chk("b2b spacing", acc_q[i] - acc_q[i-1], LAT + 1);
    chk("b2b last err", d_err, 1);

    rr_mode = 1;
    for (int i = 0; i < 200; i++)
      xact(1'($urandom_range(0, 9) < 4), rand_addr(), {$urandom, $urandom});

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 64, meaning byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of DATA_W words stored (power of two).
REQ-004 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid (legal range 1..15).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge triggered.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit, meaning the initiator presents a request.
REQ-008 The block SHALL have port req_ready, output, 1 bit, meaning the responder can accept a request.
REQ-009 The block SHALL have port req_we, input, 1 bit, meaning 1 = store and 0 = load/fetch.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits, meaning the byte address.
REQ-011 The block SHALL have port req_wdata, input, DATA_W bits, meaning the store data.
REQ-012 The block SHALL have port resp_valid, output, 1 bit, meaning a response is presented.
REQ-013 The block SHALL have port resp_ready, input, 1 bit, meaning the initiator accepts the response.
REQ-014 The block SHALL have port resp_rdata, output, DATA_W bits, meaning the load data.
REQ-015 The block SHALL have port resp_err, output, 1 bit, meaning a misaligned or out-of-range access.

Function
REQ-016 The block SHALL implement states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 The block SHALL accept a request when req_valid && req_ready is true at a rising edge, and SHALL latch we, addr and wdata at that edge.
REQ-018 On a request accepted in cycle n, the block SHALL assert resp_valid in cycle n+LATENCY, passing through WAIT when LATENCY > 1 and going IDLE->RESP directly when LATENCY = 1.
REQ-019 The block SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_valid && resp_ready, then return to IDLE on that edge.
REQ-020 A new request SHALL be accepted no earlier than the cycle after the response handshake, giving a back-to-back period of LATENCY+1 cycles.
REQ-021 Word index SHALL be addr[3 +: log2(DEPTH)] for DATA_W = 64.
REQ-022 resp_err SHALL be 1 when addr[2:0] != 0 or addr >= DEPTH*8; in that case no write occurs and resp_rdata = 0.
REQ-023 A valid store SHALL write the array on the edge entering RESP, and its response SHALL carry resp_rdata = 0 and resp_err = 0.
REQ-024 A valid load SHALL return the word stored at the latched index, and a load following a store to the same address SHALL return the new data.
REQ-025 req_valid asserted outside IDLE SHALL be ignored without side effects, and request inputs changing after acceptance SHALL not affect the transaction in flight.

Reset
REQ-026 While reset = 1 at an edge, the block SHALL go to IDLE and set resp_valid = 0, resp_rdata = 0, resp_err = 0 and the latency counter to 0.
REQ-027 req_ready SHALL be 0 in the cycle reset is sampled high and SHALL be 1 in the first cycle after reset is deasserted.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the transaction, and a pending store SHALL not be written.
REQ-029 The storage array SHALL not be reset and its contents SHALL be preserved across reset.

Structure
REQ-030 A shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default width/depth constants.
REQ-031 The storage SHALL be a sub-module mem_array with one synchronous write port and one combinational read port, instantiated once.
REQ-032 The FSM and latency counter SHALL live in mem_responder, with no other sub-modules.

Verification
REQ-033 Store 0xDEADBEEFCAFEF00D at 0x10, then load 0x10 with LATENCY = 2 -> resp_valid two cycles after each accept, rdata = 0xDEADBEEFCAFEF00D, err = 0.
REQ-034 Hold resp_ready = 0 for 5 cycles during a load -> resp_valid, rdata and err stay constant and req_ready stays 0, with completion on the cycle resp_ready rises.
REQ-035 Store to 0x13, then load 0x10 -> first response err = 1, and 0x10 still returns its prior value.
REQ-036 Load 0x800 with DEPTH = 256 -> err = 1, rdata = 0.
REQ-037 Assert reset in the WAIT cycle of a store to 0x20 -> resp_valid = 0 next cycle and req_ready = 1 after deassertion, and a subsequent load of 0x20 returns the old data.
REQ-038 With req_valid and resp_ready held high for 4 loads -> accepts spaced exactly LATENCY+1 = 3 cycles apart and responses in order.
